// File: rtl/main_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_responder_pkg
// Brief    : Shared geometry defaults and FSM state type for the main memory.
// Revision : 1.0
// ============================================================================
package main_mem_responder_pkg;

    localparam int c_ADDR_W = 12;
    localparam int c_DATA_W = 16;
    localparam int c_DEPTH  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOST  = 2'd1,
        ST_CLEAR = 2'd2
    } mmr_state_e;

endpackage : main_mem_responder_pkg
`default_nettype wire

// File: rtl/main_mem_responder_mem_array_1rw.sv
`default_nettype none
// ============================================================================
// Module   : mem_array_1rw
// Brief    : Single-port array, read-first, registered read data.
// Revision : 1.0
// ============================================================================
module mem_array_1rw
    import main_mem_responder_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_array_1rw
`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_responder
// Brief    : Processor memory with host side-port and whole-array zero fill.
// Revision : 1.0
// ============================================================================
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] main_m_addr,
    input  logic [DATA_W-1:0] main_m_data,
    input  logic              main_m_rw,
    output logic [DATA_W-1:0] main_m_q,
    input  logic              proc_hold,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    mmr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              host_ack_q;
    logic              clr_busy_q;
    logic              clr_done_q;
    logic              proc_vld_q;
    logic [DATA_W-1:0] main_hold_q;
    logic [DATA_W-1:0] host_hold_q;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;

    // Port arbitration follows the FSM; reset blocks every array write.
    always_comb begin
        w_mem_en    = !reset;
        w_mem_we    = 1'b0;
        w_mem_addr  = main_m_addr;
        w_mem_wdata = main_m_data;
        case (state_q)
            ST_IDLE: begin
                w_mem_we = main_m_rw;
            end
            ST_HOST: begin
                w_mem_we    = host_we;
                w_mem_addr  = host_addr;
                w_mem_wdata = host_wdata;
            end
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = cnt_q;
                w_mem_wdata = '0;
            end
            default: begin
                w_mem_en = 1'b0;
            end
        endcase
    end

    mem_array_1rw #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clock),
        .rst     (reset),
        .en_i    (w_mem_en),
        .we_i    (w_mem_we),
        .addr_i  (w_mem_addr),
        .wdata_i (w_mem_wdata),
        .rdata_o (w_mem_rdata)
    );

    // The shared read register belongs to whoever used the port last; each
    // consumer otherwise sees its own held copy.
    assign main_m_q   = proc_vld_q ? w_mem_rdata : main_hold_q;
    assign host_rdata = host_ack_q ? w_mem_rdata : host_hold_q;
    assign host_ack   = host_ack_q;
    assign clr_busy   = clr_busy_q;
    assign clr_done   = clr_done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            host_ack_q  <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
            proc_vld_q  <= 1'b0;
            main_hold_q <= '0;
            host_hold_q <= '0;
        end else begin
            host_ack_q  <= 1'b0;
            clr_done_q  <= 1'b0;
            main_hold_q <= main_m_q;
            host_hold_q <= host_rdata;
            proc_vld_q  <= (state_q == ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (clr_start && proc_hold) begin
                        state_q    <= ST_CLEAR;
                        clr_busy_q <= 1'b1;
                    end else if (host_req && proc_hold) begin
                        state_q <= ST_HOST;
                    end
                end
                ST_HOST: begin
                    host_ack_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (cnt_q == c_LAST_ADDR) begin
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : main_mem_responder
`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_mem_responder
// Brief    : Directed scenarios plus random traffic against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_main_mem_responder;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;

    logic          clock       = 1'b0;
    logic          reset       = 1'b1;
    logic [AW-1:0] main_m_addr = '0;
    logic [DW-1:0] main_m_data = '0;
    logic          main_m_rw   = 1'b0;
    logic [DW-1:0] main_m_q;
    logic          proc_hold   = 1'b0;
    logic          host_req    = 1'b0;
    logic          host_we     = 1'b0;
    logic [AW-1:0] host_addr   = '0;
    logic [DW-1:0] host_wdata  = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          clr_start   = 1'b0;
    logic          clr_busy;
    logic          clr_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .main_m_addr (main_m_addr),
        .main_m_data (main_m_data),
        .main_m_rw   (main_m_rw),
        .main_m_q    (main_m_q),
        .proc_hold   (proc_hold),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [DW-1:0] mm [DEPTH];
    bit            kn [DEPTH];
    logic [DW-1:0] e_q      = '0;
    logic [DW-1:0] e_hr     = '0;
    bit            e_q_kn   = 1'b1;
    bit            e_hr_kn  = 1'b1;
    bit            e_ack    = 1'b0;
    bit            e_busy   = 1'b0;
    bit            e_done   = 1'b0;
    int            clr_left = 0;
    bit            host_fly = 1'b0;
    bit            mdl_live = 1'b0;

    always @(posedge clock) begin
        mdl_live = 1'b1;
        if (reset) begin
            e_q = '0;  e_q_kn = 1'b1;
            e_hr = '0; e_hr_kn = 1'b1;
            e_ack = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            clr_left = 0; host_fly = 1'b0;
        end else begin
            e_ack  = 1'b0;
            e_done = 1'b0;
            if (clr_left > 0) begin
                mm[AW'(DEPTH - clr_left)] = '0;
                kn[AW'(DEPTH - clr_left)] = 1'b1;
                clr_left--;
                if (clr_left == 0) begin
                    e_busy = 1'b0;
                    e_done = 1'b1;
                end
            end else if (host_fly) begin
                e_hr    = mm[host_addr];
                e_hr_kn = kn[host_addr];
                if (host_we) begin
                    mm[host_addr] = host_wdata;
                    kn[host_addr] = 1'b1;
                end
                e_ack    = 1'b1;
                host_fly = 1'b0;
            end else begin
                e_q    = mm[main_m_addr];
                e_q_kn = kn[main_m_addr];
                if (main_m_rw) begin
                    mm[main_m_addr] = main_m_data;
                    kn[main_m_addr] = 1'b1;
                end
                if (clr_start && proc_hold) begin
                    clr_left = DEPTH;
                    e_busy   = 1'b1;
                end else if (host_req && proc_hold) begin
                    host_fly = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (mdl_live) begin
            chk("host_ack", 32'(host_ack), 32'(e_ack));
            chk("clr_busy", 32'(clr_busy), 32'(e_busy));
            chk("clr_done", 32'(clr_done), 32'(e_done));
            if (e_q_kn)  chk("main_m_q", 32'(main_m_q), 32'(e_q));
            if (e_hr_kn) chk("host_rdata", 32'(host_rdata), 32'(e_hr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic proc_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        main_m_addr = a; main_m_data = d; main_m_rw = 1'b1;
        cyc(1);
        main_m_rw = 1'b0;
    endtask

    task automatic proc_rd(input logic [AW-1:0] a, output logic [DW-1:0] q);
        main_m_addr = a; main_m_rw = 1'b0;
        cyc(1);
        q = main_m_q;
    endtask

    task automatic host_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output logic [DW-1:0] q, output int lat);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        lat = 0; q = '0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            lat++;
            if (host_ack) begin
                q = host_rdata;
                break;
            end
        end
        host_req = 1'b0;
    endtask

    task automatic run_clear(output int busy_n, output int done_n);
        proc_hold = 1'b1; clr_start = 1'b1;
        cyc(1);
        clr_start = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 5000 && done_n == 0; i++) begin
            if (clr_busy) busy_n++;
            if (clr_done) done_n++;
            cyc(1);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) != 0) return AW'($urandom_range(0, 15));
        return AW'($urandom);
    endfunction

    initial begin
        #50_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] q;
        int lat, busy_n, done_n, n, done_at, ack_at, early;
        bit did_clr;

        // Reset values
        cyc(3);
        chk("rst_main_m_q", 32'(main_m_q), 'h0);
        chk("rst_host_rdata", 32'(host_rdata), 'h0);
        chk("rst_host_ack", 32'(host_ack), 'h0);
        chk("rst_clr_busy", 32'(clr_busy), 'h0);
        chk("rst_clr_done", 32'(clr_done), 'h0);
        reset = 1'b0;
        cyc(2);

        // Bring the array to a known all-zero state
        run_clear(busy_n, done_n);
        chk("init_clr_busy_cycles", busy_n, 4096);
        chk("init_clr_done_count", done_n, 1);
        proc_hold = 1'b0;

        // Processor write then read, read-first on the write edge
        proc_wr(12'h005, 16'h1234);
        chk("proc_wr_read_first", 32'(main_m_q), 'h0);
        proc_rd(12'h005, q);
        chk("proc_rd_005", 32'(q), 'h1234);

        // Host write/read of the top word
        proc_hold = 1'b1;
        host_xfer(1'b1, 12'hFFF, 16'hBEEF, q, lat);
        chk("host_wr_latency", lat, 2);
        chk("host_wr_old_word", 32'(q), 'h0);
        host_xfer(1'b0, 12'hFFF, 16'h0000, q, lat);
        chk("host_rd_latency", lat, 2);
        chk("host_rd_FFF", 32'(q), 'hBEEF);

        // Back-to-back host accesses with request held high
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'hFFF;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (host_ack) n++;
        end
        host_req = 1'b0;
        chk("host_peak_rate_acks", n, 3);

        // Host blocked while processor not held
        proc_hold = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h005;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (host_ack) n++;
        end
        chk("host_blocked_acks", n, 0);
        proc_hold = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            lat++;
            if (host_ack) break;
        end
        q = host_rdata;
        host_req = 1'b0;
        chk("host_unblock_latency", lat, 2);
        chk("host_unblock_rdata", 32'(q), 'h1234);

        // Full clear wipes preloaded end words
        proc_hold = 1'b0;
        proc_wr(12'h000, 16'h1111);
        proc_wr(12'hFFF, 16'h2222);
        run_clear(busy_n, done_n);
        chk("clr_busy_cycles", busy_n, 4096);
        chk("clr_done_count", done_n, 1);
        chk("clr_done_width", 32'(clr_done), 'h0);
        proc_hold = 1'b0;
        proc_rd(12'h000, q);
        chk("clr_word_000", 32'(q), 'h0);
        proc_rd(12'hFFF, q);
        chk("clr_word_FFF", 32'(q), 'h0);

        // Clear wins over a simultaneous host request
        proc_wr(12'h777, 16'h5A5A);
        proc_hold = 1'b1; clr_start = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h777;
        cyc(1);
        clr_start = 1'b0;
        done_at = -1; ack_at = -1; early = 0; q = '1;
        for (int i = 0; i < 5000; i++) begin
            if (clr_done && done_at < 0) done_at = i;
            if (host_ack) begin
                ack_at = i;
                q = host_rdata;
                if (done_at < 0) early++;
                break;
            end
            cyc(1);
        end
        host_req = 1'b0;
        chk("clr_then_host_gap", ack_at - done_at, 2);
        chk("clr_then_host_rdata", 32'(q), 'h0);
        chk("no_ack_during_clear", early, 0);

        // Reset aborts a clear at cnt = 100
        proc_hold = 1'b0;
        cyc(1);
        proc_wr(12'd99, 16'hAAAA);
        proc_wr(12'd100, 16'hBBBB);
        proc_wr(12'd101, 16'hCCCC);
        proc_wr(12'hFFF, 16'hDDDD);
        proc_hold = 1'b1; clr_start = 1'b1;
        cyc(1);
        clr_start = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (clr_done) n++;
            cyc(1);
        end
        reset = 1'b1;
        cyc(2);
        chk("abort_busy_low", 32'(clr_busy), 'h0);
        reset = 1'b0; proc_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (clr_done) n++;
            cyc(1);
        end
        chk("abort_no_done", n, 0);
        proc_rd(12'd99, q);
        chk("abort_word_99", 32'(q), 'h0);
        proc_rd(12'd100, q);
        chk("abort_word_100", 32'(q), 'hBBBB);
        proc_rd(12'd101, q);
        chk("abort_word_101", 32'(q), 'hCCCC);
        proc_rd(12'hFFF, q);
        chk("abort_word_FFF", 32'(q), 'hDDDD);

        // Random traffic checked by the model
        did_clr = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (host_ack) begin
                host_req = 1'b0;
            end else if (!host_req && $urandom_range(0, 2) == 0) begin
                host_req   = 1'b1;
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = rand_addr();
                host_wdata = DW'($urandom);
            end
            if ($urandom_range(0, 7) == 0) proc_hold = ~proc_hold;
            main_m_addr = rand_addr();
            main_m_data = DW'($urandom);
            main_m_rw   = 1'($urandom_range(0, 1));
            clr_start   = (!did_clr && i >= 1500 && $urandom_range(0, 3) == 0);
            if (clr_start && proc_hold) did_clr = 1'b1;
            reset       = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        reset = 1'b0; host_req = 1'b0; clr_start = 1'b0; main_m_rw = 1'b0;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_main_mem_responder
`default_nettype wire
